debug_hex_overlay: RTL and testbench

- Pixel-colour source that sits directly upstream of the vga timing core.
- Consumes the core's pix_x/pix_y and produces the 16-bit colour word the core drives out.
- Renders a 32-bit debug value as 8 hex digits using a built-in 3x5 font at a fixed screen position; all other pixels pass bg_color through.
- The displayed value updates only at frame start (no tearing), via a valid/ready handshake.

---
 rtl/debug_hex_overlay_if.sv | 33 +++
 rtl/debug_hex_overlay.sv | 167 ++++++++++++++++
 tb/tb_debug_hex_overlay.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/debug_hex_overlay_if.sv
// Pixel/colour and debug-value handshake bundle between the vga core side and the hex overlay.
interface debug_hex_overlay_if;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [15:0] bg_color;
    logic        enable;
    logic [31:0] value;
    logic        value_valid;
    logic        value_ready;
    logic [15:0] color;

    modport master (
        output pix_x,
        output pix_y,
        output bg_color,
        output enable,
        output value,
        output value_valid,
        input  value_ready,
        input  color
    );

    modport slave (
        input  pix_x,
        input  pix_y,
        input  bg_color,
        input  enable,
        input  value,
        input  value_valid,
        output value_ready,
        output color
    );
endinterface

// File: rtl/debug_hex_overlay.sv
// Hex debug overlay: draws a 32-bit word as 8 3x5-font digits over bg_color; colour latency 2 cycles.
// value_ready is low while a staged word waits for the next frame start; offerer holds value_valid.
module debug_hex_overlay #(
    parameter logic [15:0] ORIGIN_X   = 16'd16,
    parameter logic [15:0] ORIGIN_Y   = 16'd16,
    parameter int          SCALE_LOG2 = 1,
    parameter logic [15:0] FG_COLOR   = 16'h0FFF
) (
    input  logic               clk,
    input  logic               rst,
    debug_hex_overlay_if.slave bus
);

    localparam logic [15:0] REGION_W = 16'(32 << SCALE_LOG2);
    localparam logic [15:0] REGION_H = 16'(6 << SCALE_LOG2);

    // Glyphs packed as five 3-bit rows, top row in the most significant bits.
    function automatic logic [14:0] glyph(input logic [3:0] nib);
        logic [14:0] g;
        case (nib)
            4'h0:    g = 15'o75557;
            4'h1:    g = 15'o26227;
            4'h2:    g = 15'o71747;
            4'h3:    g = 15'o71717;
            4'h4:    g = 15'o55711;
            4'h5:    g = 15'o74717;
            4'h6:    g = 15'o74757;
            4'h7:    g = 15'o71111;
            4'h8:    g = 15'o75757;
            4'h9:    g = 15'o75717;
            4'hA:    g = 15'o75755;
            4'hB:    g = 15'o65656;
            4'hC:    g = 15'o74447;
            4'hD:    g = 15'o65556;
            4'hE:    g = 15'o74747;
            default: g = 15'o74744;
        endcase
        return g;
    endfunction

    // Handshake / frame state
    logic        at_origin_q,   at_origin_d;
    logic        staged_full_q, staged_full_d;
    logic [31:0] staged_q,      staged_d;
    logic [31:0] displayed_q,   displayed_d;

    // Stage 1
    logic        s1_region_q,   s1_region_d;
    logic [3:0]  s1_nib_q,      s1_nib_d;
    logic [2:0]  s1_row_q,      s1_row_d;
    logic [1:0]  s1_col_q,      s1_col_d;
    logic        s1_en_q,       s1_en_d;
    logic [15:0] s1_bg_q,       s1_bg_d;

    // Stage 2
    logic [15:0] color_q,       color_d;

    logic        at_origin;
    logic        frame_start;
    logic        accept;
    logic [15:0] dx;
    logic [15:0] dy;
    logic        in_region;
    logic [4:0]  dot_x;
    logic [2:0]  dot_y;
    logic [2:0]  digit;
    logic [14:0] glyph_bits;
    logic [2:0]  row_bits;
    logic        dot_on;
    logic        lit;

    always_comb begin
        at_origin     = (bus.pix_x == 16'd0) && (bus.pix_y == 16'd0);
        frame_start   = at_origin && !at_origin_q;
        accept        = bus.value_valid && !staged_full_q;

        at_origin_d   = at_origin;
        staged_full_d = staged_full_q;
        staged_d      = staged_q;
        displayed_d   = displayed_q;

        // Swap only happens with staging full and accept only with it empty,
        // so the two never compete for the staging register.
        if (frame_start && staged_full_q) begin
            displayed_d   = staged_q;
            staged_full_d = 1'b0;
        end
        if (accept) begin
            staged_d      = bus.value;
            staged_full_d = 1'b1;
        end
    end

    always_comb begin
        dx    = bus.pix_x - ORIGIN_X;
        dy    = bus.pix_y - ORIGIN_Y;
        // The >= terms stop pixels left of / above the origin aliasing in via dx/dy underflow.
        in_region = (bus.pix_x >= ORIGIN_X) && (dx < REGION_W) &&
                    (bus.pix_y >= ORIGIN_Y) && (dy < REGION_H);
        dot_x = 5'(dx >> SCALE_LOG2);
        dot_y = 3'(dy >> SCALE_LOG2);
        digit = dot_x[4:2];

        s1_region_d = in_region;
        s1_nib_d    = displayed_q[{~digit, 2'b00} +: 4];
        s1_row_d    = dot_y;
        s1_col_d    = dot_x[1:0];
        s1_en_d     = bus.enable;
        s1_bg_d     = bus.bg_color;
    end

    always_comb begin
        glyph_bits = glyph(s1_nib_q);
        row_bits   = 3'b000;
        case (s1_row_q)
            3'd0:    row_bits = glyph_bits[14:12];
            3'd1:    row_bits = glyph_bits[11:9];
            3'd2:    row_bits = glyph_bits[8:6];
            3'd3:    row_bits = glyph_bits[5:3];
            3'd4:    row_bits = glyph_bits[2:0];
            default: row_bits = 3'b000;
        endcase

        dot_on = 1'b0;
        case (s1_col_q)
            2'd0:    dot_on = row_bits[2];
            2'd1:    dot_on = row_bits[1];
            2'd2:    dot_on = row_bits[0];
            default: dot_on = 1'b0;
        endcase

        lit     = s1_region_q && s1_en_q && (s1_col_q != 2'd3) && (s1_row_q != 3'd5) && dot_on;
        color_d = lit ? FG_COLOR : s1_bg_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            at_origin_q   <= 1'b0;
            staged_full_q <= 1'b0;
            staged_q      <= 32'd0;
            displayed_q   <= 32'd0;
            s1_region_q   <= 1'b0;
            s1_nib_q      <= 4'd0;
            s1_row_q      <= 3'd0;
            s1_col_q      <= 2'd0;
            s1_en_q       <= 1'b0;
            s1_bg_q       <= 16'd0;
            color_q       <= 16'd0;
        end else begin
            at_origin_q   <= at_origin_d;
            staged_full_q <= staged_full_d;
            staged_q      <= staged_d;
            displayed_q   <= displayed_d;
            s1_region_q   <= s1_region_d;
            s1_nib_q      <= s1_nib_d;
            s1_row_q      <= s1_row_d;
            s1_col_q      <= s1_col_d;
            s1_en_q       <= s1_en_d;
            s1_bg_q       <= s1_bg_d;
            color_q       <= color_d;
        end
    end

    assign bus.value_ready = !staged_full_q;
    assign bus.color       = color_q;

endmodule

// File: tb/tb_debug_hex_overlay.sv
// Directed bench for debug_hex_overlay: colour expectations are queued per driven pixel and popped two cycles later.
module tb_debug_hex_overlay;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_hex_overlay_if ovl ();

    debug_hex_overlay #(
        .ORIGIN_X  (16'd16),
        .ORIGIN_Y  (16'd16),
        .SCALE_LOG2(1),
        .FG_COLOR  (16'h0FFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ovl)
    );

    localparam logic [15:0] FG = 16'h0FFF;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    bit          chk_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the colour seen after this edge belongs to the pixel driven one call earlier.
    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [15:0] bg,
                         input bit chk, input logic [15:0] exp, input string tag);
        logic [15:0] e;
        bit          c;
        string       t;
        ovl.pix_x    = x;
        ovl.pix_y    = y;
        ovl.bg_color = bg;
        exp_q.push_back(exp);
        chk_q.push_back(chk);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            c = chk_q.pop_front();
            t = tag_q.pop_front();
            if (c) check(t, {16'd0, ovl.color}, {16'd0, e});
        end
    endtask

    task automatic flush();
        drive(16'd200, 16'd200, 16'h0000, 1'b0, 16'h0000, "pad");
        drive(16'd200, 16'd200, 16'h0000, 1'b0, 16'h0000, "pad");
    endtask

    task automatic clear_sb();
        exp_q.delete();
        chk_q.delete();
        tag_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bg;
        rst             = 1'b0;
        ovl.pix_x       = 16'd100;
        ovl.pix_y       = 16'd100;
        ovl.bg_color    = 16'h0000;
        ovl.enable      = 1'b1;
        ovl.value       = 32'd0;
        ovl.value_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_color", {16'd0, ovl.color}, 32'd0);
        check("reset_ready", {31'd0, ovl.value_ready}, 32'd1);
        rst = 1'b1;

        // Power-up display is "00000000"
        drive(16'd16, 16'd16, 16'h0000, 1'b1, FG, "zero_d0_r0_c0");
        flush();
        check("ready_idle", {31'd0, ovl.value_ready}, 32'd1);

        // Accept a value; it stays staged until a frame start
        ovl.value       = 32'h0123ABCD;
        ovl.value_valid = 1'b1;
        drive(16'd100, 16'd100, 16'h0000, 1'b0, 16'h0000, "pad");
        ovl.value_valid = 1'b0;
        check("ready_after_accept", {31'd0, ovl.value_ready}, 32'd0);
        drive(16'd24, 16'd16, 16'h0000, 1'b1, FG, "old_d1_c0");
        drive(16'd26, 16'd16, 16'h0000, 1'b1, FG, "old_d1_c1");
        drive(16'd0, 16'd0, 16'h0000, 1'b0, 16'h0000, "pad");
        check("ready_after_swap", {31'd0, ovl.value_ready}, 32'd1);
        drive(16'd100, 16'd100, 16'h0000, 1'b0, 16'h0000, "pad");
        drive(16'd24, 16'd16, 16'h0000, 1'b1, 16'h0000, "one_r0_c0");
        drive(16'd26, 16'd16, 16'h0000, 1'b1, FG, "one_r0_c1");
        drive(16'd18, 16'd18, 16'h0000, 1'b1, 16'h0000, "zero_r1_c1");
        drive(16'd16, 16'd18, 16'h0000, 1'b1, FG, "zero_r1_c0");
        drive(16'd22, 16'd16, 16'h0000, 1'b1, 16'h0000, "spacing_col");
        drive(16'd16, 16'd26, 16'h0000, 1'b1, 16'h0000, "row5_blank");
        drive(16'd72, 16'd16, 16'h0000, 1'b1, FG, "d7_D_r0_c0");
        drive(16'd76, 16'd16, 16'h0000, 1'b1, 16'h0000, "d7_D_r0_c2");

        // Region boundaries
        bg = 16'h0123;
        drive(16'd15, 16'd16, bg, 1'b1, bg, "left_edge");
        drive(16'd80, 16'd16, bg, 1'b1, bg, "right_edge");
        drive(16'd16, 16'd28, bg, 1'b1, bg, "bottom_edge");
        drive(16'd65535, 16'd16, bg, 1'b1, bg, "x_wrap");
        drive(16'd79, 16'd16, bg, 1'b1, bg, "last_col_spacing");
        drive(16'd16, 16'd27, bg, 1'b1, bg, "row5_last_line");
        drive(16'd16, 16'd15, bg, 1'b1, bg, "top_edge");

        // Accept coincides with frame start while staging is empty
        ovl.value       = 32'hFFFFFFFF;
        ovl.value_valid = 1'b1;
        drive(16'd0, 16'd0, 16'h0000, 1'b0, 16'h0000, "pad");
        ovl.value_valid = 1'b0;
        check("ready_coincident", {31'd0, ovl.value_ready}, 32'd0);
        drive(16'd0, 16'd0, 16'h0000, 1'b0, 16'h0000, "pad");
        drive(16'd0, 16'd0, 16'h0000, 1'b0, 16'h0000, "pad");
        check("ready_held_origin", {31'd0, ovl.value_ready}, 32'd0);
        drive(16'd20, 16'd18, 16'h0000, 1'b1, FG, "coincident_not_shown");
        drive(16'd0, 16'd0, 16'h0000, 1'b0, 16'h0000, "pad");
        check("ready_next_frame", {31'd0, ovl.value_ready}, 32'd1);
        drive(16'd100, 16'd100, 16'h0000, 1'b0, 16'h0000, "pad");
        drive(16'd20, 16'd18, 16'h0000, 1'b1, 16'h0000, "F_r1_c2");

        // Origin held 3 cycles swaps only once
        ovl.value       = 32'h11111111;
        ovl.value_valid = 1'b1;
        drive(16'd100, 16'd100, 16'h0000, 1'b0, 16'h0000, "pad");
        ovl.value_valid = 1'b0;
        drive(16'd0, 16'd0, 16'h0000, 1'b0, 16'h0000, "pad");
        check("ready_first_origin", {31'd0, ovl.value_ready}, 32'd1);
        ovl.value       = 32'h22222222;
        ovl.value_valid = 1'b1;
        drive(16'd0, 16'd0, 16'h0000, 1'b0, 16'h0000, "pad");
        ovl.value_valid = 1'b0;
        drive(16'd0, 16'd0, 16'h0000, 1'b0, 16'h0000, "pad");
        check("ready_no_second_swap", {31'd0, ovl.value_ready}, 32'd0);
        drive(16'd16, 16'd18, 16'h0000, 1'b1, FG, "held_shows_one");
        drive(16'd20, 16'd18, 16'h0000, 1'b1, 16'h0000, "held_one_r1_c2");

        // Transparent overlay
        ovl.enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bg = 16'($urandom_range(0, 65535));
            drive(16'(16 + 2 * i), 16'd16, bg, 1'b1, bg, "disabled_passthru");
        end
        ovl.enable = 1'b1;

        // Asynchronous reset mid-line
        drive(16'd16, 16'd18, 16'h0AAA, 1'b1, FG, "pre_reset");
        drive(16'd16, 16'd18, 16'h0AAA, 1'b1, FG, "pre_reset");
        check("pre_reset_color", {16'd0, ovl.color}, {16'd0, FG});
        #2;
        rst = 1'b0;
        #1;
        check("midreset_color", {16'd0, ovl.color}, 32'd0);
        check("midreset_ready", {31'd0, ovl.value_ready}, 32'd1);
        clear_sb();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(16'd20, 16'd18, 16'h0000, 1'b1, FG, "post_reset_zero");
        drive(16'd24, 16'd18, 16'h0000, 1'b1, FG, "post_reset_zero_d1");
        flush();
        check("post_reset_ready", {31'd0, ovl.value_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
